// File: rtl/instr_encode.sv
// instr_encode: packs an R/M/U instruction field bundle into a 27-bit word,
// rejects illegal bundles, and buffers legal words in a 2-entry FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   field bundle handshake (in_ready = FIFO not full)
//   fmt, base, sub        format (00 R, 01 M, 10 U, 11 illegal), basecode, subcode
//   rd, ra, rb, rm, func  register addresses / function code
//   imm                   two's-complement immediate
//   out_valid / out_ready encoded word handshake
//   out_instr             FIFO head, zero when out_valid is low
//   err                   one-cycle pulse after a rejected bundle is consumed
//   err_count             saturating count of rejected bundles
module instr_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [1:0]  base,
    input  logic [1:0]  sub,
    input  logic [3:0]  rd,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rm,
    input  logic [3:0]  func,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] out_instr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int unsigned W_INSTR = 27;
    localparam int unsigned W_CNT   = 8;
    localparam int unsigned DEPTH   = 2;

    logic [1:0]         count_q, count_d;
    logic [W_INSTR-1:0] slot0_q, slot0_d;
    logic [W_INSTR-1:0] slot1_q, slot1_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic [W_CNT-1:0]   err_count_q, err_count_d;

    logic [W_INSTR-1:0] word_c;
    logic               legal_c;
    logic [10:0]        low11_c;
    logic               imm_u_ok_c;
    logic               imm_s_ok_c;
    logic               accept_c;
    logic               push_c;
    logic               pop_c;

    assign in_ready  = (count_q != 2'(DEPTH));
    assign out_valid = out_valid_q;
    assign out_instr = slot0_q;
    assign err       = err_q;
    assign err_count = err_count_q;

    // Field packing and legality check for the bundle currently presented.
    always_comb begin
        word_c  = '0;
        legal_c = 1'b0;
        low11_c = func[3] ? imm[10:0] : {7'b0, rb};
        // Immediate fits when all bits above the field's sign bit replicate it.
        imm_u_ok_c = (imm[31:20] == {12{imm[20]}});
        imm_s_ok_c = (imm[31:10] == {22{imm[10]}});
        case (fmt)
            2'b00: begin
                word_c  = {rd, 2'b00, sub[1], func, ra, sub[0], low11_c};
                legal_c = (sub != 2'b11) && (!func[3] || imm_s_ok_c);
            end
            2'b01: begin
                word_c  = {func, 2'b00, 1'b1, rm, ra, 1'b1, low11_c};
                legal_c = !func[3] || imm_s_ok_c;
            end
            2'b10: begin
                word_c  = {rd, base, imm[20:0]};
                legal_c = (base != 2'b00) && imm_u_ok_c;
            end
            default: begin
                word_c  = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    // FIFO / error bookkeeping. slot0 is the head; unused slots are held at
    // zero so the head can drive out_instr directly.
    always_comb begin
        accept_c    = in_valid && in_ready;
        push_c      = accept_c && legal_c;
        pop_c       = out_valid_q && out_ready;
        count_d     = count_q;
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        err_d       = accept_c && !legal_c;
        err_count_d = err_count_q;

        if (err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + W_CNT'(1);
        end

        case (count_q)
            2'd0: begin
                if (push_c) begin
                    slot0_d = word_c;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    slot0_d = word_c;
                end else if (push_c) begin
                    slot1_d = word_c;
                    count_d = 2'd2;
                end else if (pop_c) begin
                    slot0_d = '0;
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen.
                if (pop_c) begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    count_d = 2'd1;
                end
            end
        endcase

        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            count_q     <= count_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Directed testbench for instr_encode: hand-computed vectors for encoding,
// rejection, backpressure, saturation and asynchronous reset.
module tb_instr_encode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [1:0]  base;
    logic [1:0]  sub;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rm;
    logic [3:0]  func;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_instr;
    logic        err;
    logic [7:0]  err_count;

    int total_cnt;
    int pass_cnt;

    instr_encode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .base      (base),
        .sub       (sub),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .rm        (rm),
        .func      (func),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [1:0] b, input logic [1:0] s,
                         input logic [3:0] d, input logic [3:0] a, input logic [3:0] r_b,
                         input logic [3:0] r_m, input logic [3:0] fn, input logic [31:0] im);
        in_valid = 1'b1;
        fmt = f; base = b; sub = s; rd = d; ra = a; rb = r_b; rm = r_m; func = fn; imm = im;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        in_valid  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // U format, latency 1
        drive(2'b10, 2'b10, 2'b00, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 32'h123);
        step();
        in_valid = 1'b0;
        chk("u_valid", 32'(out_valid), 32'd1);
        chk("u_word", 32'(out_instr), 32'h2C00123);
        chk("u_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        step();
        chk("u_pop_valid", 32'(out_valid), 32'd0);
        chk("u_pop_zero", 32'(out_instr), 32'd0);

        // R then M with push+pop at occupancy 1
        drive(2'b00, 2'b00, 2'b00, 4'd3, 4'd2, 4'd0, 4'd0, 4'd9, 32'hFFFFFFFF);
        step();
        chk("r_valid", 32'(out_valid), 32'd1);
        chk("r_word", 32'(out_instr), 32'h18927FF);
        drive(2'b01, 2'b00, 2'b00, 4'd0, 4'd1, 4'd0, 4'd7, 4'hC, 32'd8);
        step();
        in_valid = 1'b0;
        chk("m_valid_kept", 32'(out_valid), 32'd1);
        chk("m_word", 32'(out_instr), 32'h6171808);
        chk("m_occ1_ready", 32'(in_ready), 32'd1);
        step();
        chk("m_drained", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(2'b10, 2'b01, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'd1);
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        drive(2'b10, 2'b11, 2'b00, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 32'd2);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        step();
        drive(2'b10, 2'b01, 2'b00, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 32'd3);
        chk("bp_ready2_low", 32'(in_ready), 32'd0);
        step();
        chk("bp_head_a", 32'(out_instr), 32'h0A00001);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        chk("bp_full_with_ready", 32'(in_ready), 32'd0);
        step();
        chk("bp_head_b", 32'(out_instr), 32'h1600002);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_head_c", 32'(out_instr), 32'h1A00003);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_ready_high", 32'(in_ready), 32'd1);

        // Rejections
        drive(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 32'd1024);
        step();
        in_valid = 1'b0;
        chk("rej_no_valid", 32'(out_valid), 32'd0);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_cnt1", 32'(err_count), 32'd1);
        step();
        chk("rej_err_pulse", 32'(err), 32'd0);
        chk("rej_cnt1_hold", 32'(err_count), 32'd1);
        drive(2'b11, 2'b01, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        step();
        drive(2'b10, 2'b00, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'd1);
        step();
        drive(2'b00, 2'b00, 2'b11, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        step();
        drive(2'b10, 2'b01, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'h00100000);
        step();
        in_valid = 1'b0;
        chk("rej_cnt5", 32'(err_count), 32'd5);
        chk("rej_none_pushed", 32'(out_valid), 32'd0);

        // Legal boundaries
        drive(2'b10, 2'b01, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'hFFF00000);
        step();
        chk("u_min_imm", 32'(out_instr), 32'h0300000);
        chk("u_min_err", 32'(err), 32'd0);
        drive(2'b00, 2'b00, 2'b01, 4'd1, 4'd4, 4'd6, 4'd0, 4'd2, 32'h7FFFFFFF);
        step();
        chk("r_rb_form", 32'(out_instr), 32'h0824806);
        drive(2'b00, 2'b00, 2'b10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 32'hFFFFFC00);
        step();
        in_valid = 1'b0;
        chk("r_min_imm", 32'(out_instr), 32'h0180400);
        chk("r_min_cnt", 32'(err_count), 32'd5);
        step();
        chk("bound_drained", 32'(out_valid), 32'd0);

        // Saturation
        drive(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        for (int i = 0; i < 300; i++) step();
        chk("sat_255", 32'(err_count), 32'd255);
        chk("sat_err", 32'(err), 32'd1);
        step();
        in_valid = 1'b0;
        chk("sat_hold", 32'(err_count), 32'd255);
        step();

        // Reset with two words buffered
        out_ready = 1'b0;
        drive(2'b10, 2'b01, 2'b00, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'd1);
        step();
        drive(2'b10, 2'b11, 2'b00, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 32'd2);
        step();
        in_valid = 1'b0;
        chk("prerst_full", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_instr", 32'(out_instr), 32'd0);
        chk("arst_cnt", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(2'b10, 2'b10, 2'b00, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 32'h123);
        step();
        in_valid = 1'b0;
        chk("post_rst_word", 32'(out_instr), 32'h2C00123);
        step();
        chk("post_rst_alone", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port in_valid  in  1  field bundle valid.
REQ-004 SHALL have port in_ready  out  1  block can accept a bundle this cycle.
REQ-005 SHALL have port fmt  in  2  format: 00 R, 01 M, 10 U, 11 illegal.
REQ-006 SHALL have port base  in  2  basecode, U format only.
REQ-007 SHALL have port sub  in  2  subcode, R format only.
REQ-008 SHALL have ports rd, ra, rb, rm, func  in  4 each  register addresses / function code.
REQ-009 SHALL have port imm  in  32  two's-complement immediate.
REQ-010 SHALL have port out_valid  out  1  encoded word available.
REQ-011 SHALL have port out_ready  in  1  consumer takes word.
REQ-012 SHALL have port out_instr  out  27  encoded instruction word.
REQ-013 SHALL have port err  out  1  one-cycle pulse: last accepted bundle rejected.
REQ-014 SHALL have port err_count  out  8  saturating count of rejected bundles.

Function
REQ-015 SHALL encode U format as [26:23]=rd, [22:21]=base, [20:0]=imm[20:0].
REQ-016 SHALL encode R format as [26:23]=rd, [22:21]=00, [20]=sub[1], [19:16]=func, [15:12]=ra, [11]=sub[0], [10:0]=imm[10:0] if func[3] else {7'b0, rb}.
REQ-017 SHALL encode M format as [26:23]=func, [22:21]=00, [20]=1, [19:16]=rm, [15:12]=ra, [11]=1, [10:0] as REQ-016.
REQ-018 SHALL reject a bundle: fmt=11; U with base=00; R with sub=11; U with imm outside -1048576..1048575; R/M with func[3]=1 and imm outside -1024..1023.
REQ-019 SHALL ignore imm range when func[3]=0 in R/M, and ignore unused fields per format.
REQ-020 SHALL hold encoded words in a 2-entry FIFO; in_ready = (occupancy < 2), combinational from state only.
REQ-021 SHALL on in_valid&in_ready of a legal bundle push its word at that edge; out_valid asserted next cycle (latency 1) when FIFO was empty.
REQ-022 SHALL pop the head on out_valid&out_ready; out_instr = head entry, stable while out_valid&!out_ready.
REQ-023 SHALL allow push and pop in the same cycle when occupancy is 1 (occupancy unchanged, order preserved).
REQ-024 SHALL deassert in_ready when occupancy is 2 even if out_ready is high that cycle.
REQ-025 SHALL consume a rejected bundle (handshake completes) without pushing; err=1 the following cycle only; err_count += 1, holding at 255.
REQ-026 SHALL drive out_instr = 0 when out_valid=0.
REQ-027 SHALL deliver words in acceptance order; no word lost or duplicated.

Reset
REQ-028 SHALL on rst_n=0 immediately clear FIFO (occupancy 0), out_valid=0, out_instr=0, err=0, err_count=0; in_ready=1 once rst_n=1.
REQ-029 SHALL discard any buffered or in-flight word when reset asserts mid-operation; no handshake completes while rst_n=0.

Verification
REQ-030 SHALL verify U: fmt=10, base=10, rd=5, imm=0x123 -> out_instr=0x2C00123 one cycle later, err=0.
REQ-031 SHALL verify R: fmt=00, sub=00, rd=3, func=9, ra=2, imm=-1 -> 0x18927FF; M: fmt=01, func=0xC, rm=7, ra=1, imm=8 -> 0x6171808.
REQ-032 SHALL verify backpressure: out_ready=0, three back-to-back legal bundles -> two accepted, in_ready=0 from the third cycle; out_ready=1 -> words drain in order, in_ready returns high.
REQ-033 SHALL verify rejection: fmt=00, func=8, imm=1024 -> no out_valid, err pulse 1 cycle, err_count=1; 300 rejects -> err_count=255.
REQ-034 SHALL verify occupancy 1 with push and pop same cycle -> out_valid stays 1, next word correct, occupancy 1.
REQ-035 SHALL verify rst_n low with 2 words buffered -> out_valid=0, err_count=0 asynchronously; first post-reset bundle appears alone.
